inst_axi_bridge: RTL

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/inst_axi_bridge.sv
// ---------------------------------------------------------------------------
// inst_axi_bridge
//
// Read-only bridge from the if_stage SRAM-style fetch interface to an AXI
// read master. Each fetch becomes a single-beat AXI read (arlen=0). The AR
// channel is driven by a two-state FSM. An outstanding counter limits how many
// reads may be in flight and gates rready.
//
// Configuration macro:
//   IBRIDGE_OUTSTANDING2_EN  defined   -> up to 2 reads in flight
//                            undefined -> 1 read in flight; the next AR is
//                                         issued only after the previous
//                                         data_ok
//
// Parameters:
//   ARID               AXI ID driven on arid. Only R beats carrying this ID
//                      complete a fetch.
//
// Ports:
//   clk, reset         single clock; synchronous active-high reset
//   inst_sram_en       fetch request
//   inst_sram_wen      write strobe, ignored
//   inst_sram_size     request size, latched into arsize[1:0]
//   inst_sram_addr     fetch address
//   inst_sram_wdata    ignored
//   inst_sram_addr_ok  one-cycle pulse on the AR handshake
//   inst_sram_data_ok  one-cycle pulse, one cycle after a completing R beat
//   inst_sram_rdata    fetched word; holds between data_ok pulses
//   ar*                AXI read-address channel
//   r*                 AXI read-data channel
//
// State table (AR FSM):
//   state   | meaning
//   AR_IDLE | no request held; arvalid=0; latch a new fetch if depth allows
//   AR_BUSY | request latched; arvalid=1 with araddr/arsize held until arready
// ---------------------------------------------------------------------------
module inst_axi_bridge #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  // if_stage fetch port
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read-address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI read-data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

`ifdef IBRIDGE_OUTSTANDING2_EN
  localparam logic [1:0] MAX_OUTSTANDING = 2'd2;
`else
  localparam logic [1:0] MAX_OUTSTANDING = 2'd1;
`endif

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  ar_state_t   ar_state_q, ar_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  arsize_q, arsize_d;
  logic        arvalid_q, arvalid_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;

  logic ar_hs;
  logic r_hs;
  logic r_done;
  logic rready_w;

  // Write-side inputs and rresp have no effect on a read-only bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rresp};

  // Handshake-visible outputs are gated with reset so they read as idle for
  // the whole time reset is high, not just after the first reset edge.
  assign rready_w = (outstanding_q != 2'd0) && !reset;
  assign ar_hs    = arvalid_q && arready && !reset;
  assign r_hs     = rvalid && rready_w;
  // Foreign-ID beats are still accepted (rready is high) but never complete
  // a fetch. arlen=0, so a matching beat always carries rlast.
  assign r_done   = r_hs && (rid == ARID) && rlast;

  // AR FSM next state
  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    arvalid_d  = arvalid_q;
    case (ar_state_q)
      AR_IDLE: begin
        // The counter only covers handshaken reads; the request held in
        // AR_BUSY is added at its handshake, and IDLE re-checks the updated
        // count the cycle after.
        if (inst_sram_en && (outstanding_q < MAX_OUTSTANDING)) begin
          ar_state_d = AR_BUSY;
          araddr_d   = inst_sram_addr;
          arsize_d   = inst_sram_size;
          arvalid_d  = 1'b1;
        end
      end
      AR_BUSY: begin
        // inst_sram_en is not looked at here: a latched request always
        // completes its handshake.
        if (ar_hs) begin
          ar_state_d = AR_IDLE;
          arvalid_d  = 1'b0;
        end
      end
      default: begin
        ar_state_d = AR_IDLE;
        arvalid_d  = 1'b0;
      end
    endcase
  end

  // Outstanding counter. An increment needs outstanding<MAX (checked when the
  // request was latched) and a decrement needs rready, i.e. outstanding>0, so
  // the counter stays inside [0, MAX] by construction.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({ar_hs, r_done})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Read-data return path: one cycle from R handshake to data_ok
  always_comb begin
    data_ok_d = r_done;
    rdata_d   = rdata_q;
    if (r_done) begin
      rdata_d = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state_q    <= AR_IDLE;
      araddr_q      <= 32'h0;
      arsize_q      <= 2'b10;
      arvalid_q     <= 1'b0;
      outstanding_q <= 2'd0;
      data_ok_q     <= 1'b0;
      rdata_q       <= 32'h0;
    end else begin
      ar_state_q    <= ar_state_d;
      araddr_q      <= araddr_d;
      arsize_q      <= arsize_d;
      arvalid_q     <= arvalid_d;
      outstanding_q <= outstanding_d;
      data_ok_q     <= data_ok_d;
      rdata_q       <= rdata_d;
    end
  end

  assign arid              = ARID;
  assign arlen             = 8'd0;
  assign arsize            = {1'b0, arsize_q};
  assign araddr            = araddr_q;
  assign arvalid           = arvalid_q && !reset;
  assign rready            = rready_w;
  assign inst_sram_addr_ok = ar_hs;
  assign inst_sram_data_ok = data_ok_q && !reset;
  assign inst_sram_rdata   = rdata_q;

endmodule
